// File: rtl/apb4_archinfo.sv
// APB4 architecture-information block: one writable SoC configuration word (SYS)
// followed by a read-only 64-bit chip identifier (IDL/IDH), repeated every 16 bytes.
module apb4_archinfo #(
    parameter logic [31:0] SYS_VAL = 32'h0000_0101,
    parameter logic [31:0] IDL_VAL = 32'hFFFF_2023,
    parameter logic [31:0] IDH_VAL = 32'hFFFF_0001
) (
    input  logic        i_pclk,
    input  logic        i_presetn,
    input  logic [31:0] i_paddr,
    input  logic [2:0]  i_pprot,
    input  logic        i_psel,
    input  logic        i_penable,
    input  logic        i_pwrite,
    input  logic [31:0] i_pwdata,
    input  logic [3:0]  i_pstrb,
    output logic        o_pready,
    output logic [31:0] o_prdata,
    output logic        o_pslverr
);

    localparam logic [1:0] ADDR_SYS = 2'd0;
    localparam logic [1:0] ADDR_IDL = 2'd1;
    localparam logic [1:0] ADDR_IDH = 2'd2;

    logic [31:0] r_sys;
    logic [1:0]  w_reg_sel;
    logic        w_wr_en;
    logic        w_rd_en;
    logic        w_sys_wr;

    // Only the word index is decoded; the rest of the address simply aliases.
    assign w_reg_sel = i_paddr[3:2];
    assign w_wr_en   = i_psel & i_penable & i_pwrite;
    assign w_rd_en   = i_psel & ~i_pwrite;
    assign w_sys_wr  = w_wr_en & (w_reg_sel == ADDR_SYS);

    logic w_unused_ok;
    assign w_unused_ok = ^{i_pprot, i_paddr[31:4], i_paddr[1:0]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sys_lane
            always_ff @(posedge i_pclk or negedge i_presetn) begin
                if (!i_presetn) begin
                    r_sys[8*gi +: 8] <= SYS_VAL[8*gi +: 8];
                end else if (w_sys_wr && i_pstrb[gi]) begin
                    r_sys[8*gi +: 8] <= i_pwdata[8*gi +: 8];
                end
            end
        end
    endgenerate

    // Read mux is valid in both setup and access phases so no wait states are needed.
    always_comb begin
        o_prdata = 32'h0;
        if (w_rd_en) begin
            case (w_reg_sel)
                ADDR_SYS: o_prdata = r_sys;
                ADDR_IDL: o_prdata = IDL_VAL;
                ADDR_IDH: o_prdata = IDH_VAL;
                default:  o_prdata = 32'h0;
            endcase
        end
    end

    assign o_pready  = 1'b1;
    assign o_pslverr = 1'b0;

endmodule

// File: tb/tb_apb4_archinfo.sv
// Directed bench for apb4_archinfo: APB reads/writes with hand-computed expected values.
module tb_apb4_archinfo;

    logic        clk;
    logic        presetn;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int n_checks = 0;
    int n_pass   = 0;

    apb4_archinfo dut (
        .i_pclk    (clk),
        .i_presetn (presetn),
        .i_paddr   (paddr),
        .i_pprot   (pprot),
        .i_psel    (psel),
        .i_penable (penable),
        .i_pwrite  (pwrite),
        .i_pwdata  (pwdata),
        .i_pstrb   (pstrb),
        .o_pready  (pready),
        .o_prdata  (prdata),
        .o_pslverr (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    endtask

    // Entered just after a rising edge; leaves the bus idle just after the commit edge.
    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input string tag);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = addr; pwdata = data; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        check({tag, "_prdata"},  prdata,          32'h0);
        check({tag, "_pready"},  {31'h0, pready},  32'h1);
        check({tag, "_pslverr"}, {31'h0, pslverr}, 32'h0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = 4'h0;
        $display("WRITE addr=%08h data=%08h strb=%b", addr, data, strb);
    endtask

    task automatic apb_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        #1;
        check({tag, "_setup"}, prdata, exp);
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        check({tag, "_access"},  prdata,           exp);
        check({tag, "_pready"},  {31'h0, pready},  32'h1);
        check({tag, "_pslverr"}, {31'h0, pslverr}, 32'h0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        $display("READ  addr=%08h data=%08h expected=%08h", addr, prdata, exp);
    endtask

    initial begin
        presetn = 1'b0; paddr = 32'h0; pprot = 3'h0; psel = 1'b0; penable = 1'b0;
        pwrite = 1'b0; pwdata = 32'h0; pstrb = 4'h0;

        repeat (40) @(posedge clk);
        #1;
        check("rst_prdata",  prdata,           32'h0);
        check("rst_pready",  {31'h0, pready},  32'h1);
        check("rst_pslverr", {31'h0, pslverr}, 32'h0);
        presetn = 1'b1;
        @(posedge clk); #1;

        apb_read(32'h0, 32'h0000_0101, "def_sys");
        apb_read(32'h4, 32'hFFFF_2023, "def_idl");
        apb_read(32'h8, 32'hFFFF_0001, "def_idh");
        apb_read(32'hC, 32'h0000_0000, "def_unmap");

        apb_write(32'h0, 32'hDEAD_BEEF, 4'hF, "wr_full");
        apb_read(32'h0, 32'hDEAD_BEEF, "rd_full");

        apb_write(32'h0, 32'h1234_5678, 4'b0101, "wr_part");
        apb_read(32'h0, 32'hDE34_BE78, "rd_part");

        apb_write(32'h4, 32'h0, 4'hF, "wr_idl");
        apb_write(32'h8, 32'h0, 4'hF, "wr_idh");
        apb_write(32'hC, 32'h0, 4'hF, "wr_unmap");
        apb_read(32'h4, 32'hFFFF_2023, "ro_idl");
        apb_read(32'h8, 32'hFFFF_0001, "ro_idh");
        apb_read(32'hC, 32'h0000_0000, "ro_unmap");
        apb_read(32'h0, 32'hDE34_BE78, "ro_sys_kept");

        apb_read(32'h14, 32'hFFFF_2023, "alias_idl");
        apb_write(32'h10, 32'hA5A5_A5A5, 4'hF, "wr_alias");
        apb_read(32'h0, 32'hA5A5_A5A5, "rd_alias");
        apb_read(32'hFFFF_FF03, 32'hA5A5_A5A5, "alias_hi_lo");

        apb_write(32'h0, 32'h1122_3344, 4'b1010, "wr_part2");
        apb_read(32'h0, 32'h11A5_33A5, "rd_part2");

        // Reset lands in the access phase of a write; SYS must return to default
        // immediately, before any clock edge, and the write must be lost.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h0; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        presetn = 1'b0;
        #1;
        pwrite = 1'b0; penable = 1'b0;
        #1;
        check("midrst_async", prdata, 32'h0000_0101);
        pwrite = 1'b1; penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        presetn = 1'b1;
        $display("RESET mid-write released");
        @(posedge clk); #1;
        apb_read(32'h0, 32'h0000_0101, "midrst_sys");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
